// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream program loader feeding a CPU instruction fetch port
module program_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int PC_WIDTH    = 16
) (
    input  logic                           i_clk,
    input  logic                           i_reset_n,
    input  logic                           i_load_start,
    input  logic                           i_load_finish,
    input  logic                           i_load_valid,
    input  logic [7:0]                     i_load_byte,
    output logic                           o_load_ready,
    output logic [$clog2(DEPTH_WORDS):0]   o_word_count,
    output logic                           o_overflow,
    output logic                           o_partial,
    output logic                           o_cpu_reset_n,
    input  logic [PC_WIDTH-1:0]            i_pc,
    output logic [31:0]                    o_instruction
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN} state_t;

    state_t        r_state;
    logic [AW:0]   r_word_count;
    logic [1:0]    r_byte_idx;
    logic [23:0]   r_staging;
    logic          r_overflow;
    logic          r_partial;
    logic          r_cpu_reset_n;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_full;
    logic          w_store;
    logic          w_write;
    logic [1:0]    w_idx_next;
    logic [PC_WIDTH-1:0] w_pc_word;
    logic          w_pc_hit;

    assign o_load_ready = (r_state == ST_LOAD) && !i_load_start;
    assign w_accept     = i_load_valid && o_load_ready;
    assign w_full       = (r_word_count == FULL_COUNT);
    assign w_store      = w_accept && !w_full;
    assign w_write      = w_store && (r_byte_idx == 2'd3);
    // The 2-bit index wraps 3 -> 0 naturally when the word completes.
    assign w_idx_next   = w_store ? r_byte_idx + 2'd1 : r_byte_idx;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_word_count  <= '0;
            r_byte_idx    <= '0;
            r_staging     <= '0;
            r_overflow    <= 1'b0;
            r_partial     <= 1'b0;
            r_cpu_reset_n <= 1'b0;
        end else if (i_load_start) begin
            r_state       <= ST_LOAD;
            r_word_count  <= '0;
            r_byte_idx    <= '0;
            r_staging     <= '0;
            r_overflow    <= 1'b0;
            r_partial     <= 1'b0;
            r_cpu_reset_n <= 1'b0;
        end else if (r_state == ST_LOAD) begin
            if (w_accept && w_full)
                r_overflow <= 1'b1;
            if (w_write)
                r_word_count <= r_word_count + 1'b1;
            if (w_store) begin
                case (r_byte_idx)
                    2'd0:    r_staging[7:0]   <= i_load_byte;
                    2'd1:    r_staging[15:8]  <= i_load_byte;
                    2'd2:    r_staging[23:16] <= i_load_byte;
                    default: r_staging        <= r_staging;
                endcase
            end
            // A byte arriving with finish is folded in before judging the leftover.
            if (i_load_finish) begin
                r_state       <= ST_RUN;
                r_cpu_reset_n <= 1'b1;
                r_byte_idx    <= '0;
                if (w_idx_next != 2'd0)
                    r_partial <= 1'b1;
            end else begin
                r_byte_idx <= w_idx_next;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_write)
            r_mem[r_word_count[AW-1:0]] <= {i_load_byte, r_staging};
    end

    // Comparing the whole shifted PC against the count also rejects nonzero high bits.
    assign w_pc_word     = i_pc >> 2;
    assign w_pc_hit      = (r_state == ST_RUN) && (w_pc_word < PC_WIDTH'(r_word_count));
    assign o_instruction = w_pc_hit ? r_mem[w_pc_word[AW-1:0]] : 32'h0;

    assign o_word_count  = r_word_count;
    assign o_overflow    = r_overflow;
    assign o_partial     = r_partial;
    assign o_cpu_reset_n = r_cpu_reset_n;

endmodule

// File: doc/program_loader.md
# program_loader

Instruction-memory front end that sits directly upstream of the CPU fetch stage. It receives a program as a little-endian byte stream over a valid/ready port and assembles the bytes into 32-bit words in internal instruction RAM. It holds the CPU in reset while loading, then releases it. While the CPU runs, it serves the instruction word addressed by the CPU's program counter.

## Interface
- DEPTH_WORDS, 256: instruction RAM depth in 32-bit words; must be a power of 2, at most 16384.
- PC_WIDTH, 16: width of the CPU program-counter bus.

- i_clk  input  1  clock; all state changes on the rising edge.
- i_reset_n  input  1  reset; asynchronous, active-low.
- i_load_start  input  1  single-cycle pulse: enter LOAD and restart at word 0.
- i_load_finish  input  1  single-cycle pulse: end LOAD and enter RUN.
- i_load_valid  input  1  a byte is presented on i_load_byte.
- i_load_byte  input  8  program byte, little-endian within each word.
- o_load_ready  output  1  the loader accepts a byte this cycle.
- o_word_count  output  log2(DEPTH_WORDS)+1  number of complete words written since the last start.
- o_overflow  output  1  sticky: a byte arrived after the RAM was full.
- o_partial  output  1  sticky: finish arrived with 1-3 bytes of an incomplete word pending.
- o_cpu_reset_n  output  1  registered active-low reset for the CPU.
- i_pc  input  PC_WIDTH  CPU program counter (byte address).
- o_instruction  output  32  instruction word for i_pc.

## Operation
- States: IDLE, LOAD, RUN.
  - IDLE→LOAD on i_load_start.
  - LOAD→RUN on i_load_finish.
  - RUN→LOAD on i_load_start.
  - LOAD→LOAD on i_load_start: restart.
  - No other transitions.
- Handshake:
  - o_load_ready = (state==LOAD) && !i_load_start. It is combinational.
  - A byte is accepted on any edge where i_load_valid && o_load_ready.
- Word assembly:
  - A 2-bit byte index counts from 0 to 3.
  - Byte k goes to bits [8k+7:8k] of a word staging register.
  - When the byte with index 3 is accepted, the full word (staging bytes 0-2 plus the incoming byte) is written to RAM at word address o_word_count on that same edge. o_word_count then increments and the byte index wraps to 0.
- Full RAM:
  - When o_word_count == DEPTH_WORDS, accepted bytes are discarded.
  - o_overflow sets and o_word_count saturates.
  - The handshake still completes, so the source never deadlocks.
- Start:
  - i_load_start clears o_word_count, the byte index, the staging register, o_overflow and o_partial.
  - RAM contents are retained, not cleared.
- Finish:
  - If the byte index is nonzero, o_partial sets and the pending bytes are discarded (not written).
  - The byte index clears.
- Simultaneous events:
  - i_load_start and i_load_finish together: start wins.
  - Start and a valid byte together: the byte is not accepted.
  - Finish and an accepted byte together (in LOAD): the byte is processed first. If it completes a word, the word is written and no partial is flagged.
  - Pulses that have no valid transition in the current state are ignored.
- Instruction read (combinational):
  - Word index = i_pc[log2(DEPTH_WORDS)+1:2]. i_pc[1:0] is ignored.
  - o_instruction = RAM[index] only if state==RUN and the index is below o_word_count. Otherwise it is 32'h0 (NOP).
  - PC bits above the index field do not alias: a nonzero value there returns 0.
- CPU reset: o_cpu_reset_n is a register that captures (next_state==RUN).

## Timing
- Reset values, applied asynchronously on i_reset_n low:
  - state=IDLE.
  - o_word_count=0, byte index=0, staging=0.
  - o_overflow=0, o_partial=0.
  - o_cpu_reset_n=0.
  - o_load_ready=0 and o_instruction=0 follow from the state.
- Reset mid-load: the load is abandoned and all counters return to their reset values.
- Byte acceptance: a new byte can be accepted every cycle. Four accepted bytes produce one RAM write, on the edge of the fourth byte.
- A word written on edge N is readable on o_instruction from the cycle after edge N, once in RUN.
- Entering RUN:
  - The finish pulse is sampled on edge N.
  - State is RUN and o_cpu_reset_n=1 after edge N; both change on the same edge.
  - The CPU's first fetch edge is N+1, at pc 0.
- Leaving RUN: a start sampled on edge N makes o_cpu_reset_n=0 after edge N and o_instruction=0 immediately.
- All outputs except o_load_ready and o_instruction are registered.

## Test plan
- Load, sequence 1 (with DEPTH_WORDS=256): reset; start; bytes 01 02 03 04 05 06 07 08 streamed back-to-back; finish.
  - o_word_count=2 and o_cpu_reset_n=1 one edge after finish.
  - i_pc=0 → o_instruction=32'h04030201.
  - i_pc=4 → 32'h08070605.
  - i_pc=8 → 0.
- Load, sequence 2: sequence 1 loaded, then a second start with only bytes AA BB CC DD, then finish.
  - o_word_count=1.
  - i_pc=0 → 32'hDDCCBBAA.
  - i_pc=4 → 0, even though the RAM still holds 32'h08070605.
- Partial word and invalid handshakes: start; bytes 11 22 33 44 55; finish.
  - o_partial=1 and o_word_count=1.
  - Bytes presented in IDLE or RUN see o_load_ready=0 and have no effect.
- Overflow: DEPTH_WORDS=4; stream 20 bytes.
  - o_word_count saturates at 4.
  - o_overflow=1.
  - o_load_ready stays 1 throughout LOAD.
  - Words 0-3 are intact.
- Simultaneous events: finish together with the 4th byte writes the word, and o_partial=0. Start together with finish stays in LOAD with counters cleared. Start together with a valid byte does not accept that byte.
- Asynchronous reset in RUN: all outputs go to their reset values without waiting for a clock edge (o_cpu_reset_n=0, o_instruction=0). A subsequent start/finish cycle resumes normal operation.
